axi4_mem_slave: RTL and testbench



---
 rtl/axi4_mem_slave.sv | 267 ++++++++++++++++++++++++++
 tb/tb_axi4_mem_slave.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_mem_slave.sv
// AXI4 memory-model responder: independent write (AW/W/B) and read (AR/R) FSMs
// sharing a register-array memory; IDs are echoed unchanged on B and R.
//
// state  | meaning
// W_IDLE | waiting for AW, AWREADY high
// W_DATA | accepting AWLEN+1 write beats, WREADY high
// W_RESP | presenting B until BREADY
// R_IDLE | waiting for AR, ARREADY high
// R_DATA | presenting ARLEN+1 read beats on R
module axi4_mem_slave #(
    parameter int ID_WIDTH   = 6,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int MEM_DEPTH  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ID_WIDTH-1:0]       awid,
    input  logic [ADDR_WIDTH-1:0]     awaddr,
    input  logic [7:0]                awlen,
    input  logic [2:0]                awsize,
    input  logic [1:0]                awburst,
    input  logic [1:0]                awlock,
    input  logic [3:0]                awcache,
    input  logic [2:0]                awprot,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [DATA_WIDTH/8-1:0]   wstrb,
    input  logic                      wlast,
    input  logic                      wvalid,
    output logic                      wready,
    output logic [ID_WIDTH-1:0]       bid,
    output logic [1:0]                bresp,
    output logic                      bvalid,
    input  logic                      bready,
    input  logic [ID_WIDTH-1:0]       arid,
    input  logic [ADDR_WIDTH-1:0]     araddr,
    input  logic [7:0]                arlen,
    input  logic [2:0]                arsize,
    input  logic [1:0]                arburst,
    input  logic [1:0]                arlock,
    input  logic [3:0]                arcache,
    input  logic [2:0]                arport,
    input  logic                      arvalid,
    output logic                      arready,
    output logic [ID_WIDTH-1:0]       rid,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic [DATA_WIDTH/8-1:0]   rstrb,
    output logic                      rlast,
    output logic                      rvalid,
    input  logic                      rready
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int BYTE_SHIFT = $clog2(STRB_WIDTH);
    localparam int IDX_WIDTH  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(MEM_DEPTH);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    function automatic logic [ADDR_WIDTH-1:0] next_addr(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [2:0]            size,
        input logic [1:0]            burst
    );
        logic [ADDR_WIDTH-1:0] step;
        step = ADDR_WIDTH'(1) << size;
        return (burst == 2'b01) ? addr + step : addr;
    endfunction

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic unused_sideband;
    assign unused_sideband = ^{awlock, awcache, awprot, arlock, arcache, arport};

    // ---------------- write channel ----------------
    w_state_t              w_state, w_next;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [7:0]            w_len, w_cnt;
    logic [2:0]            w_size;
    logic [1:0]            w_burst;
    logic [ID_WIDTH-1:0]   w_id;
    logic                  w_slverr, w_decerr, w_bad;
    logic                  aw_hs, w_hs, b_hs;
    logic                  w_last_beat, wlast_err;
    logic [ADDR_WIDTH:0]   w_diff;
    logic [ADDR_WIDTH-1:0] w_word;
    logic                  w_inrange;
    logic [IDX_WIDTH-1:0]  w_idx;
    logic                  awready_d, wready_d, bvalid_d;
    logic [1:0]            bresp_d;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;
    assign b_hs  = bvalid && bready;
    assign w_bad = w_burst[1];

    // The borrow bit of the widened subtraction flags addresses below BASE_ADDR.
    assign w_diff    = {1'b0, w_addr} - {1'b0, BASE_ADDR};
    assign w_word    = w_diff[ADDR_WIDTH-1:0] >> BYTE_SHIFT;
    assign w_inrange = !w_diff[ADDR_WIDTH] && (w_word < DEPTH_A);
    assign w_idx     = w_word[IDX_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state  <= W_IDLE;
            awready  <= 1'b0;
            wready   <= 1'b0;
            bvalid   <= 1'b0;
            bid      <= '0;
            bresp    <= '0;
            w_id     <= '0;
            w_addr   <= '0;
            w_len    <= '0;
            w_size   <= '0;
            w_burst  <= '0;
            w_cnt    <= '0;
            w_slverr <= 1'b0;
            w_decerr <= 1'b0;
        end else begin
            w_state <= w_next;
            awready <= awready_d;
            wready  <= wready_d;
            bvalid  <= bvalid_d;
            if (aw_hs) begin
                w_id     <= awid;
                w_addr   <= awaddr;
                w_len    <= awlen;
                w_size   <= awsize;
                w_burst  <= awburst;
                w_cnt    <= '0;
                w_slverr <= awburst[1];
                w_decerr <= 1'b0;
            end
            if (w_hs) begin
                w_addr   <= next_addr(w_addr, w_size, w_burst);
                w_cnt    <= w_cnt + 8'd1;
                w_slverr <= w_slverr | wlast_err;
                w_decerr <= w_decerr | !w_inrange;
                if (w_last_beat) begin
                    bid   <= w_id;
                    bresp <= bresp_d;
                end
            end
        end
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_next = W_DATA;
            W_DATA:  if (w_hs && w_last_beat) w_next = W_RESP;
            W_RESP:  if (b_hs) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        awready_d   = (w_next == W_IDLE);
        wready_d    = (w_next == W_DATA);
        bvalid_d    = (w_next == W_RESP);
        w_last_beat = (w_cnt == w_len);
        wlast_err   = (wlast != w_last_beat);
        if (w_slverr || wlast_err)
            bresp_d = 2'b10;
        else if (w_decerr || !w_inrange)
            bresp_d = 2'b11;
        else
            bresp_d = 2'b00;
    end

    always_ff @(posedge clk) begin
        if (!rst && w_hs && w_inrange && !w_bad) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (wstrb[b])
                    mem[w_idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // ---------------- read channel ----------------
    r_state_t              r_state, r_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_len, r_cnt;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic                  ar_hs, r_hs;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_bad;
    logic [ADDR_WIDTH:0]   rd_diff;
    logic [ADDR_WIDTH-1:0] rd_word_idx;
    logic                  rd_inrange;
    logic [IDX_WIDTH-1:0]  rd_idx;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  arready_d, rvalid_d;

    assign ar_hs = arvalid && arready;
    assign r_hs  = rvalid && rready;

    // In idle the fetch address comes straight from AR so beat 0 is ready with RVALID.
    assign rd_addr     = (r_state == R_IDLE) ? araddr : r_addr;
    assign rd_bad      = (r_state == R_IDLE) ? arburst[1] : r_burst[1];
    assign rd_diff     = {1'b0, rd_addr} - {1'b0, BASE_ADDR};
    assign rd_word_idx = rd_diff[ADDR_WIDTH-1:0] >> BYTE_SHIFT;
    assign rd_inrange  = !rd_diff[ADDR_WIDTH] && (rd_word_idx < DEPTH_A);
    assign rd_idx      = rd_word_idx[IDX_WIDTH-1:0];
    assign rd_word     = (rd_inrange && !rd_bad) ? mem[rd_idx] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rstrb   <= '0;
            rid     <= '0;
            rdata   <= '0;
            rlast   <= 1'b0;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_size  <= '0;
            r_burst <= '0;
        end else begin
            r_state <= r_next;
            arready <= arready_d;
            rvalid  <= rvalid_d;
            rstrb   <= rvalid_d ? '1 : '0;
            if (ar_hs) begin
                rid     <= arid;
                rdata   <= rd_word;
                rlast   <= (arlen == 8'd0);
                r_addr  <= next_addr(araddr, arsize, arburst);
                r_len   <= arlen;
                r_cnt   <= '0;
                r_size  <= arsize;
                r_burst <= arburst;
            end else if (r_hs) begin
                if (rlast) begin
                    rlast <= 1'b0;
                end else begin
                    rdata  <= rd_word;
                    rlast  <= ((r_cnt + 8'd1) == r_len);
                    r_addr <= next_addr(r_addr, r_size, r_burst);
                    r_cnt  <= r_cnt + 8'd1;
                end
            end
        end
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_DATA;
            R_DATA:  if (r_hs && rlast) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        arready_d = (r_next == R_IDLE);
        rvalid_d  = (r_next == R_DATA);
    end

endmodule

// File: tb/tb_axi4_mem_slave.sv
// Directed bench for axi4_mem_slave: single and burst accesses, backpressure,
// out-of-range and protocol errors, concurrent read/write and mid-burst reset.
module tb_axi4_mem_slave;

    localparam int LIMIT = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  awid, bid, arid, rid;
    logic [31:0] awaddr, araddr;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, awprot, arsize, arport;
    logic [1:0]  awburst, awlock, bresp, arburst, arlock;
    logic [3:0]  awcache, arcache;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic [63:0] wdata, rdata;
    logic [7:0]  wstrb, rstrb;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    axi4_mem_slave dut (
        .clk(clk), .rst(rst),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache), .arport(arport),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rstrb(rstrb), .rlast(rlast), .rvalid(rvalid),
        .rready(rready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag, input int n);
        if (n >= LIMIT) begin
            checks++;
            errors++;
            $error("FAIL %s timeout observed=%0d cycles expected<%0d", tag, n, LIMIT);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_aw(input logic [5:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [1:0] burst);
        int n = 0;
        awid = id; awaddr = addr; awlen = len; awsize = 3'd3; awburst = burst;
        awvalid = 1'b1;
        while (!awready && n < LIMIT) begin step(); n++; end
        timeout("aw_wait", n);
        step();
        awvalid = 1'b0;
        chk("awready_drop", awready, 1'b0);
    endtask

    task automatic send_w(input logic [63:0] data, input logic [7:0] strb, input logic last);
        int n = 0;
        wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
        while (!wready && n < LIMIT) begin step(); n++; end
        timeout("w_wait", n);
        step();
        wvalid = 1'b0;
    endtask

    task automatic recv_b(input logic [5:0] id, input logic [1:0] resp);
        int n = 0;
        bready = 1'b1;
        while (!bvalid && n < LIMIT) begin step(); n++; end
        timeout("b_wait", n);
        chk("bid", bid, id);
        chk("bresp", bresp, resp);
        step();
        bready = 1'b0;
        chk("bvalid_clear", bvalid, 1'b0);
    endtask

    task automatic send_ar(input logic [5:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [1:0] burst);
        int n = 0;
        arid = id; araddr = addr; arlen = len; arsize = 3'd3; arburst = burst;
        arvalid = 1'b1;
        while (!arready && n < LIMIT) begin step(); n++; end
        timeout("ar_wait", n);
        step();
        arvalid = 1'b0;
        chk("rvalid_latency", rvalid, 1'b1);
    endtask

    task automatic recv_r(input logic [63:0] data, input logic last, input logic [5:0] id);
        int n = 0;
        rready = 1'b1;
        while (!rvalid && n < LIMIT) begin step(); n++; end
        timeout("r_wait", n);
        chk("rdata", rdata, data);
        chk("rlast", rlast, last);
        chk("rid", rid, id);
        step();
        rready = 1'b0;
    endtask

    // Presents a beat with RREADY low for one cycle first; data must hold.
    task automatic recv_r_hold(input logic [63:0] data, input logic last);
        int n = 0;
        rready = 1'b0;
        while (!rvalid && n < LIMIT) begin step(); n++; end
        timeout("r_hold_wait", n);
        chk("rdata_pre", rdata, data);
        chk("rlast_pre", rlast, last);
        step();
        chk("rdata_hold", rdata, data);
        chk("rlast_hold", rlast, last);
        chk("rvalid_hold", rvalid, 1'b1);
        rready = 1'b1;
        step();
        rready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
        awlock = '0; awcache = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
        arlock = '0; arcache = '0; arport = '0; arvalid = 1'b0; rready = 1'b0;

        repeat (3) step();
        chk("rst_awready", awready, 1'b0);
        chk("rst_arready", arready, 1'b0);
        chk("rst_bvalid", bvalid, 1'b0);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_rdata", rdata, 64'h0);
        rst = 1'b0;
        step();
        chk("post_rst_awready", awready, 1'b1);
        chk("post_rst_arready", arready, 1'b1);
        chk("post_rst_wready", wready, 1'b0);

        // single write then read
        send_aw(6'h15, 32'h40, 8'd0, 2'b01);
        chk("b_before_w", bvalid, 1'b0);
        send_w(64'hDEADBEEF_CAFEF00D, 8'hFF, 1'b1);
        chk("b_latency", bvalid, 1'b1);
        recv_b(6'h15, 2'b00);
        send_ar(6'h2A, 32'h40, 8'd0, 2'b01);
        recv_r(64'hDEADBEEF_CAFEF00D, 1'b1, 6'h2A);
        chk("rvalid_after_last", rvalid, 1'b0);

        // INCR burst with partial strobe and read backpressure
        send_aw(6'h01, 32'h108, 8'd0, 2'b01);
        send_w(64'hAAAAAAAA_BBBBBBBB, 8'hFF, 1'b1);
        recv_b(6'h01, 2'b00);
        send_aw(6'h03, 32'h100, 8'd3, 2'b01);
        send_w(64'd1, 8'hFF, 1'b0);
        send_w(64'd2, 8'h0F, 1'b0);
        send_w(64'd3, 8'hFF, 1'b0);
        chk("burst_b_early", bvalid, 1'b0);
        send_w(64'd4, 8'hFF, 1'b1);
        recv_b(6'h03, 2'b00);
        send_ar(6'h04, 32'h100, 8'd3, 2'b01);
        chk("burst_rid", rid, 6'h04);
        chk("burst_rstrb", rstrb, 8'hFF);
        recv_r_hold(64'd1, 1'b0);
        recv_r_hold(64'hAAAAAAAA_00000002, 1'b0);
        recv_r_hold(64'd3, 1'b0);
        recv_r_hold(64'd4, 1'b1);
        chk("burst_rvalid_end", rvalid, 1'b0);

        // out of range (word index 1024)
        send_aw(6'h05, 32'h2000, 8'd0, 2'b01);
        send_w(64'h1234, 8'hFF, 1'b1);
        recv_b(6'h05, 2'b11);
        send_ar(6'h06, 32'h2000, 8'd0, 2'b01);
        recv_r(64'h0, 1'b1, 6'h06);

        // WRAP burst rejected, memory untouched
        send_aw(6'h08, 32'h40, 8'd0, 2'b10);
        send_w(64'h1111, 8'hFF, 1'b1);
        recv_b(6'h08, 2'b10);
        send_ar(6'h09, 32'h40, 8'd0, 2'b01);
        recv_r(64'hDEADBEEF_CAFEF00D, 1'b1, 6'h09);

        // early WLAST: burst still runs two beats, SLVERR
        send_aw(6'h0A, 32'h200, 8'd1, 2'b01);
        send_w(64'd5, 8'hFF, 1'b1);
        chk("early_wlast_no_b", bvalid, 1'b0);
        send_w(64'd6, 8'hFF, 1'b1);
        chk("early_wlast_b", bvalid, 1'b1);
        recv_b(6'h0A, 2'b10);

        // prefill 0x300..0x338 with 0x100+i
        send_aw(6'h0C, 32'h300, 8'd7, 2'b01);
        for (int i = 0; i < 8; i++)
            send_w(64'h100 + 64'(i), 8'hFF, (i == 7));
        recv_b(6'h0C, 2'b00);

        // write and read of 0x300 handshake on the same edge
        send_aw(6'h07, 32'h300, 8'd0, 2'b01);
        wdata = 64'hFFFF0000_FFFF0000; wstrb = 8'hFF; wlast = 1'b1; wvalid = 1'b1;
        arid = 6'h11; araddr = 32'h300; arlen = 8'd7; arsize = 3'd3; arburst = 2'b01;
        arvalid = 1'b1;
        chk("conc_wready", wready, 1'b1);
        chk("conc_arready", arready, 1'b1);
        step();
        wvalid = 1'b0; arvalid = 1'b0;
        chk("conc_rvalid", rvalid, 1'b1);
        chk("conc_old_data", rdata, 64'h100);
        chk("conc_rid", rid, 6'h11);
        chk("conc_rlast0", rlast, 1'b0);
        chk("conc_bvalid", bvalid, 1'b1);
        chk("conc_bresp", bresp, 2'b00);
        bready = 1'b1; rready = 1'b1;
        step();
        bready = 1'b0;
        chk("conc_bvalid_clear", bvalid, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            chk("conc_beat", rdata, 64'h100 + 64'(i));
            chk("conc_beat_valid", rvalid, 1'b1);
            if (i < 3) step();
        end
        rst = 1'b1;
        step();
        chk("rst_mid_rvalid", rvalid, 1'b0);
        chk("rst_mid_arready", arready, 1'b0);
        chk("rst_mid_awready", awready, 1'b0);
        rst = 1'b0; rready = 1'b0;
        step();
        chk("rst_rel_arready", arready, 1'b1);
        chk("rst_rel_awready", awready, 1'b1);
        send_ar(6'h12, 32'h300, 8'd0, 2'b01);
        recv_r(64'hFFFF0000_FFFF0000, 1'b1, 6'h12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
